// File: rtl/ats21_pkg.sv
// Shared types and widths for the ATS21 initiator.
package ats21_pkg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned DATA_W = 24;

  typedef enum logic [1:0] {
    StatOk    = 2'b00,
    StatRetry = 2'b01,
    StatErr   = 2'b10,
    StatRsvd  = 2'b11
  } stat_t;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_t;

endpackage

// File: rtl/ats21_initiator.sv
// ATS21 request initiator: captures a local command, issues it, retries on RETRY,
// abandons on timeout and reports one result pulse per transaction.
module ats21_initiator
  import ats21_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CTRL_W-1:0] cmd_ctrlA,
  input  logic [CTRL_W-1:0] cmd_ctrlB,
  output logic              req,
  output logic [CTRL_W-1:0] ctrlA,
  output logic [CTRL_W-1:0] ctrlB,
  input  logic              ready,
  input  logic [1:0]        stat,
  input  logic [DATA_W-1:0] data,
  output logic              rsp_valid,
  output logic [1:0]        rsp_stat,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned RW = $clog2(MAX_RETRY) + 1;
  localparam logic [TW-1:0] TLast    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRY);

  state_t            state_q, state_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [CTRL_W-1:0] ctrl_a_q, ctrl_a_d;
  logic [CTRL_W-1:0] ctrl_b_q, ctrl_b_d;
  stat_t             rsp_stat_q, rsp_stat_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    retry_d       = retry_q;
    ctrl_a_d      = ctrl_a_q;
    ctrl_b_d      = ctrl_b_q;
    rsp_stat_d    = rsp_stat_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ctrl_a_d      = cmd_ctrlA;
          ctrl_b_d      = cmd_ctrlB;
          retry_d       = '0;
          rsp_timeout_d = 1'b0;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        tcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // A ready response wins over timeout expiry on the same edge.
        if (ready) begin
          case (stat_t'(stat))
            StatOk: begin
              rsp_stat_d = StatOk;
              rsp_data_d = data;
              state_d    = StDone;
            end
            StatRetry: begin
              if (retry_q < RetryMax) begin
                retry_d = retry_q + 1'b1;
                state_d = StIssue;
              end else begin
                rsp_stat_d = StatRetry;
                rsp_data_d = data;
                state_d    = StDone;
              end
            end
            default: begin
              rsp_stat_d = StatErr;
              rsp_data_d = data;
              state_d    = StDone;
            end
          endcase
        end else if (tcnt_q == TLast) begin
          rsp_timeout_d = 1'b1;
          rsp_stat_d    = StatErr;
          state_d       = StDone;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      tcnt_q        <= '0;
      retry_q       <= '0;
      ctrl_a_q      <= '0;
      ctrl_b_q      <= '0;
      rsp_stat_q    <= StatOk;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      retry_q       <= retry_d;
      ctrl_a_q      <= ctrl_a_d;
      ctrl_b_q      <= ctrl_b_d;
      rsp_stat_q    <= rsp_stat_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign req         = (state_q == StIssue);
  assign rsp_valid   = (state_q == StDone);
  assign ctrlA       = ctrl_a_q;
  assign ctrlB       = ctrl_b_q;
  assign rsp_stat    = rsp_stat_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_ats21_initiator.sv
// Directed, table-driven bench for ats21_initiator with hand-written reset sequences.
module tb_ats21_initiator;

  localparam int MaxRetry = 3;
  localparam int Timeout  = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_ctrlA, cmd_ctrlB;
  logic        req;
  logic [15:0] ctrlA, ctrlB;
  logic        ready;
  logic [1:0]  stat;
  logic [23:0] data;
  logic        rsp_valid;
  logic [1:0]  rsp_stat;
  logic [23:0] rsp_data;
  logic        rsp_timeout;
  logic        busy;

  int tests  = 0;
  int failed = 0;
  int req_cnt = 0;
  int rsp_cnt = 0;

  always #5 clk = ~clk;

  ats21_initiator #(
    .TIMEOUT_CYCLES(Timeout),
    .MAX_RETRY     (MaxRetry)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ctrlA  (cmd_ctrlA),
    .cmd_ctrlB  (cmd_ctrlB),
    .req        (req),
    .ctrlA      (ctrlA),
    .ctrlB      (ctrlB),
    .ready      (ready),
    .stat       (stat),
    .data       (data),
    .rsp_valid  (rsp_valid),
    .rsp_stat   (rsp_stat),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .busy       (busy)
  );

  always @(negedge clk) begin
    if (req) req_cnt <= req_cnt + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          n_retry;   // RETRY responses before the final one
    int          mode;      // 1: final ready response, 0: never ready (timeout)
    logic [1:0]  fstat;
    int          wait_n;    // ready=0 cycles before each ready response
    logic [23:0] data;
    logic [1:0]  exp_stat;
    logic [23:0] exp_data;
    int          exp_req;
    logic        exp_to;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int  r0;
    int  v0;
    bit  done;
    r0   = req_cnt;
    v0   = rsp_cnt;
    done = 0;
    cmd_valid = 1'b1;
    cmd_ctrlA = v.a;
    cmd_ctrlB = v.b;
    step();               // accepted; now ISSUE
    cmd_valid = 1'b0;
    cmd_ctrlA = 16'hDEAD;
    cmd_ctrlB = 16'hBEEF;
    step();               // WAIT cycle 0
    for (int k = 0; k < v.n_retry; k++) begin
      repeat (v.wait_n) step();
      ready = 1'b1;
      stat  = 2'b01;
      data  = v.data;
      step();
      ready = 1'b0;
      if (k < MaxRetry) step();
      else done = 1;
    end
    if (!done) begin
      if (v.mode == 1) begin
        repeat (v.wait_n) step();
        ready = 1'b1;
        stat  = v.fstat;
        data  = v.data;
        step();
        ready = 1'b0;
      end else begin
        repeat (Timeout) step();
      end
    end
    check($sformatf("v%0d rsp_valid", idx), 32'(rsp_valid), 32'd1);
    check($sformatf("v%0d rsp_stat", idx), 32'(rsp_stat), 32'(v.exp_stat));
    check($sformatf("v%0d rsp_data", idx), 32'(rsp_data), 32'(v.exp_data));
    check($sformatf("v%0d rsp_timeout", idx), 32'(rsp_timeout), 32'(v.exp_to));
    check($sformatf("v%0d ctrlA", idx), 32'(ctrlA), 32'(v.a));
    check($sformatf("v%0d ctrlB", idx), 32'(ctrlB), 32'(v.b));
    step();
    check($sformatf("v%0d idle cmd_ready", idx), 32'(cmd_ready), 32'd1);
    check($sformatf("v%0d idle rsp_valid", idx), 32'(rsp_valid), 32'd0);
    check($sformatf("v%0d req pulses", idx), 32'(req_cnt - r0), 32'(v.exp_req));
    check($sformatf("v%0d rsp pulses", idx), 32'(rsp_cnt - v0), 32'd1);
    check($sformatf("v%0d held rsp_stat", idx), 32'(rsp_stat), 32'(v.exp_stat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    vecs[0] = '{16'h1234, 16'hABCD, 0, 1, 2'b00, 3,  24'hC0FFEE, 2'b00, 24'hC0FFEE, 1, 1'b0};
    vecs[1] = '{16'h1111, 16'h2222, 3, 1, 2'b00, 1,  24'h123456, 2'b00, 24'h123456, 4, 1'b0};
    vecs[2] = '{16'h3333, 16'h4444, 4, 1, 2'b00, 0,  24'hABCDEF, 2'b01, 24'hABCDEF, 4, 1'b0};
    vecs[3] = '{16'h5555, 16'h6666, 0, 1, 2'b10, 2,  24'h0F0F0F, 2'b10, 24'h0F0F0F, 1, 1'b0};
    vecs[4] = '{16'h7777, 16'h8888, 0, 1, 2'b11, 0,  24'h555555, 2'b10, 24'h555555, 1, 1'b0};
    vecs[5] = '{16'h9999, 16'hAAAA, 0, 0, 2'b00, 0,  24'h000000, 2'b10, 24'h555555, 1, 1'b1};
    vecs[6] = '{16'hBBBB, 16'hCCCC, 0, 1, 2'b00, 31, 24'h777777, 2'b00, 24'h777777, 1, 1'b0};
    vecs[7] = '{16'hDDDD, 16'hEEEE, 1, 0, 2'b00, 2,  24'h999999, 2'b10, 24'h777777, 2, 1'b1};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_ctrlA = '0;
    cmd_ctrlB = '0;
    ready     = 1'b0;
    stat      = 2'b00;
    data      = '0;
    step();
    step();
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req", 32'(req), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset outputs", {7'd0, rsp_timeout, rsp_stat, rsp_data}, 32'd0);
    check("reset ctrl", {ctrlA, ctrlB}, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_txn(i, vecs[i]);

    // Reset in the middle of WAIT abandons the transaction silently.
    v0 = rsp_cnt;
    cmd_valid = 1'b1;
    cmd_ctrlA = 16'h4242;
    cmd_ctrlB = 16'h2424;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    step();
    check("mid busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    check("mid-reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid-reset busy", 32'(busy), 32'd0);
    check("mid-reset ctrlA", 32'(ctrlA), 32'd0);
    check("mid-reset rsp_data", 32'(rsp_data), 32'd0);
    reset = 1'b0;
    ready = 1'b1;
    stat  = 2'b00;
    data  = 24'hFFFFFF;
    repeat (3) step();
    check("stray ready busy", 32'(busy), 32'd0);
    check("stray ready rsp_data", 32'(rsp_data), 32'd0);
    check("stray ready no rsp", 32'(rsp_cnt - v0), 32'd0);
    ready = 1'b0;

    // Reset wins over a command presented on the same edge.
    reset     = 1'b1;
    cmd_valid = 1'b1;
    step();
    check("reset vs cmd busy", 32'(busy), 32'd0);
    reset     = 1'b0;
    cmd_valid = 1'b0;
    step();

    // Back-to-back reuse after reset still works.
    run_txn(8, vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
